// File: rtl/rsa_crt_decrypt.sv
// Sequential RSA-CRT decryption core, m = c^d mod (p*q). All arithmetic is bit-serial:
// restoring division, interleaved shift-add modmul and square-and-multiply modexp.
module rsa_crt_decrypt #(
  parameter int W  = 32,
  parameter int EW = 2*W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   p,
  input  logic [W-1:0]   q,
  input  logic [2*W-1:0] c,
  input  logic [EW-1:0]  d,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [2*W-1:0] m,
  output logic [W-1:0]   qinv,
  output logic [W-1:0]   h
);
  localparam int DW = (2*W > EW) ? 2*W : EW;
  localparam int CW = $clog2(DW + 2) + 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_W  = CW'(W);
  localparam logic [CW-1:0] CNT_DL = CW'(DW - 1);

  typedef enum logic [3:0] {IDLE, CHK, RED, EXP1, EXP2, EXP3, HCALC, MCALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        p_q, p_d, q_q, q_d;
  logic [2:0][DW-1:0]  dvd_q, dvd_d;
  logic [4:0][W-1:0]   rem_q, rem_d, rem_n, dvs;
  logic [4:0]          dbit;
  logic [W:0]          r2;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                ph_q, ph_d;
  logic [W-1:0]        acc_q, acc_d, e_q, e_d;
  logic [W-1:0]        mm_a_q, mm_a_d, mm_b_q, mm_b_d, mm_r_q, mm_r_d;
  logic [W-1:0]        m1_q, m1_d, m2_q, m2_d, qi_q, qi_d, hi_q, hi_d;
  logic [2*W-1:0]      prod_q, prod_d, m_q, m_d;
  logic [W-1:0]        qinv_q, qinv_d, h_q, h_d;
  logic                err_q, err_d;
  logic [W-1:0]        n_s, base_s, t_s, acc_new;
  logic [W+1:0]        mm_t;
  logic [W:0]          s_s;

  assign busy = (state_q != IDLE) && (state_q != DONE);
  assign done = (state_q == DONE);
  assign err  = err_q;
  assign m    = m_q;
  assign qinv = qinv_q;
  assign h    = h_q;

  always_comb begin
    state_d = state_q;  p_d = p_q;  q_d = q_q;  dvd_d = dvd_q;  rem_d = rem_q;
    cnt_d = cnt_q;  bit_d = bit_q;  ph_d = ph_q;  acc_d = acc_q;  e_d = e_q;
    mm_a_d = mm_a_q;  mm_b_d = mm_b_q;  mm_r_d = mm_r_q;
    m1_d = m1_q;  m2_d = m2_q;  qi_d = qi_q;  hi_d = hi_q;  prod_d = prod_q;
    m_d = m_q;  qinv_d = qinv_q;  h_d = h_q;  err_d = err_q;

    // Lanes: c mod p, c mod q, d mod (p-1), d mod (q-1), q mod p (base for the inverse)
    dvs  = {p_q, q_q - W'(1), p_q - W'(1), q_q, p_q};
    dbit = {dvd_q[2][DW-1], dvd_q[1][DW-1], dvd_q[1][DW-1], dvd_q[0][DW-1], dvd_q[0][DW-1]};
    r2   = '0;
    for (int i = 0; i < 5; i++) begin
      r2 = {rem_q[i], dbit[i]};
      if (r2 >= {1'b0, dvs[i]}) r2 = r2 - {1'b0, dvs[i]};
      rem_n[i] = r2[W-1:0];
    end

    n_s = (state_q == EXP2) ? q_q : p_q;
    case (state_q)
      EXP1:    base_s = rem_q[0];
      EXP2:    base_s = rem_q[1];
      default: base_s = rem_q[4];
    endcase
    // One modmul step: r = 2r + b_msb*a, then fold back below n (value is < 3n).
    mm_t = {1'b0, mm_r_q, 1'b0} + (mm_b_q[W-1] ? {2'b00, mm_a_q} : '0);
    if (mm_t >= {1'b0, n_s, 1'b0})  mm_t = mm_t - {1'b0, n_s, 1'b0};
    else if (mm_t >= {2'b00, n_s})  mm_t = mm_t - {2'b00, n_s};
    acc_new = e_q[W-1] ? mm_r_q : acc_q;
    // (m1 - m2) mod p; acc_q holds m2 mod p during the second HCALC multiply.
    t_s = p_q - acc_q;
    s_s = {1'b0, m1_q} + {1'b0, t_s};
    if (s_s >= {1'b0, p_q}) s_s = s_s - {1'b0, p_q};

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = CHK;  p_d = p;  q_d = q;
          dvd_d[0] = DW'(c);  dvd_d[1] = DW'(d);  dvd_d[2] = DW'(q);
          rem_d = '0;  cnt_d = '0;  ph_d = 1'b0;
          m_d = '0;  qinv_d = '0;  h_d = '0;  err_d = 1'b0;
        end
      end
      CHK: begin
        if (p_q < W'(3) || !p_q[0] || q_q < W'(2) || p_q == q_q) begin
          err_d = 1'b1;  state_d = DONE;
        end else state_d = RED;
      end
      RED: begin
        rem_d = rem_n;
        for (int i = 0; i < 3; i++) dvd_d[i] = {dvd_q[i][DW-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_DL) begin
          state_d = EXP1;  cnt_d = '0;  acc_d = W'(1);  bit_d = BW'(W-1);
          ph_d = 1'b0;  e_d = rem_n[2];
        end
      end
      EXP1, EXP2, EXP3, HCALC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == '0) begin
          mm_r_d = '0;
          if (state_q == HCALC) begin
            mm_a_d = ph_q ? qi_q : W'(1);
            mm_b_d = ph_q ? s_s[W-1:0] : m2_q;
          end else begin
            mm_a_d = acc_q;
            mm_b_d = ph_q ? base_s : acc_q;
          end
        end else if (cnt_q <= CNT_W) begin
          mm_r_d = mm_t[W-1:0];
          mm_b_d = mm_b_q << 1;
        end else begin
          cnt_d = '0;
          ph_d  = ~ph_q;
          if (!ph_q) acc_d = mm_r_q;
          else if (state_q == HCALC) begin
            hi_d = mm_r_q;  state_d = MCALC;
          end else begin
            // Multiply is always performed; its result is kept only for a set bit.
            acc_d = acc_new;  e_d = e_q << 1;  bit_d = bit_q - BW'(1);
            if (bit_q == '0) begin
              acc_d = W'(1);  bit_d = BW'(W-1);
              case (state_q)
                EXP1:    begin m1_d = acc_new; state_d = EXP2; e_d = rem_q[3]; end
                EXP2:    begin m2_d = acc_new; state_d = EXP3; e_d = p_q - W'(2); end
                default: begin qi_d = acc_new; state_d = HCALC; end
              endcase
            end
          end
        end
      end
      MCALC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == '0) begin
          prod_d = '0;  mm_b_d = hi_q;
        end else if (cnt_q <= CNT_W) begin
          prod_d = {prod_q[2*W-2:0], 1'b0} + (mm_b_q[W-1] ? {{W{1'b0}}, q_q} : '0);
          mm_b_d = mm_b_q << 1;
        end else begin
          m_d = prod_q + {{W{1'b0}}, m2_q};
          qinv_d = qi_q;  h_d = hi_q;  cnt_d = '0;  state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;  p_q <= '0;  q_q <= '0;  dvd_q <= '0;  rem_q <= '0;
      cnt_q <= '0;  bit_q <= '0;  ph_q <= 1'b0;  acc_q <= '0;  e_q <= '0;
      mm_a_q <= '0;  mm_b_q <= '0;  mm_r_q <= '0;
      m1_q <= '0;  m2_q <= '0;  qi_q <= '0;  hi_q <= '0;  prod_q <= '0;
      m_q <= '0;  qinv_q <= '0;  h_q <= '0;  err_q <= 1'b0;
    end else begin
      state_q <= state_d;  p_q <= p_d;  q_q <= q_d;  dvd_q <= dvd_d;  rem_q <= rem_d;
      cnt_q <= cnt_d;  bit_q <= bit_d;  ph_q <= ph_d;  acc_q <= acc_d;  e_q <= e_d;
      mm_a_q <= mm_a_d;  mm_b_q <= mm_b_d;  mm_r_q <= mm_r_d;
      m1_q <= m1_d;  m2_q <= m2_d;  qi_q <= qi_d;  hi_q <= hi_d;  prod_q <= prod_d;
      m_q <= m_d;  qinv_q <= qinv_d;  h_q <= h_d;  err_q <= err_d;
    end
  end
endmodule
